fft_peak_pick: RTL and testbench

Per-frame spectral peak picker between the FFT core and the bin-to-note lookup. Takes one complex FFT bin per accepted beat and forms its squared magnitude. Over one frame, it tracks the strongest bin inside the musical search window, then emits that bin index once per frame on a 32-bit bus that feeds the note lookup's `i_f_domain_idx` directly.

---
 rtl/fft_peak_pick.sv | 208 ++++++++++++++++++++
 tb/tb_fft_peak_pick.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_pick.sv
// fft_peak_pick: per-frame spectral peak picker.
// Stage 1 registers |X|^2 and the bin index of each accepted FFT beat.
// Stage 2 tracks the strongest in-window bin above threshold and publishes
// it once per frame, two cycles after the closing beat.
//
// Handshake: i_valid qualifies i_re/i_im/i_last for one cycle and is always
// consumed (there is no ready). o_valid is a one-cycle pulse; the result
// fields stay stable until the next pulse.
module fft_peak_pick #(
    parameter int DATA_W  = 16,
    parameter int N_BINS  = 512,
    parameter int BIN_LO  = 13,
    parameter int BIN_HI  = 57,
    parameter int MIN_MAG = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    input  logic                     i_last,
    output logic                     o_valid,
    output logic [31:0]              o_f_domain_idx,
    output logic [2*DATA_W-1:0]      o_peak_mag,
    output logic                     o_found,
    output logic                     o_overrun,
    output logic [1:0]               o_dbg_state
);

    localparam int IDX_W = $clog2(N_BINS);
    localparam int MAG_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Stage 0: magnitude and frame-close detection on the raw beat
    logic signed [MAG_W-1:0] re_x, im_x, re_sq, im_sq;
    logic [MAG_W-1:0]        mag_in;
    logic                    at_limit;
    logic                    close_in;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Stage 1 registers
    logic                    s1_valid_q;
    logic [MAG_W-1:0]        s1_mag_q;
    logic [IDX_W-1:0]        s1_idx_q;
    logic                    s1_last_q;
    logic                    s1_ovr_q;

    // Running best and published result
    logic [MAG_W-1:0]        best_mag_q, best_mag_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic                    best_found_q, best_found_d;
    logic [31:0]             out_idx_q, out_idx_d;
    logic [MAG_W-1:0]        out_mag_q, out_mag_d;
    logic                    out_found_q, out_found_d;
    logic                    out_ovr_q, out_ovr_d;

    // Stage 2 compare signals
    logic                    in_window;
    logic                    above_min;
    logic [MAG_W-1:0]        base_mag;
    logic [IDX_W-1:0]        base_idx;
    logic                    base_found;
    logic                    win;
    logic [MAG_W-1:0]        post_mag;
    logic [IDX_W-1:0]        post_idx;
    logic                    post_found;
    logic                    close_s1;

    // Squared magnitude; worst case 2^(2*DATA_W-1) fits in MAG_W unsigned
    always_comb begin
        re_x     = {{DATA_W{i_re[DATA_W-1]}}, i_re};
        im_x     = {{DATA_W{i_im[DATA_W-1]}}, i_im};
        re_sq    = re_x * re_x;
        im_sq    = im_x * im_x;
        mag_in   = $unsigned(re_sq) + $unsigned(im_sq);
        at_limit = (idx_q == IDX_W'(N_BINS - 1));
        close_in = i_last | at_limit;
        idx_d    = idx_q;
        if (i_valid) begin
            idx_d = close_in ? '0 : idx_q + 1'b1;
        end
    end

    // Beat index counter and stage-1 pipeline register; reset drops a same-cycle beat
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_idx_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_ovr_q   <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_mag_q  <= mag_in;
                s1_idx_q  <= idx_q;
                s1_last_q <= close_in;
                s1_ovr_q  <= at_limit & ~i_last;
            end
        end
    end

    // Stage 2 compare; in REPORT the incoming beat starts a fresh frame, so it sees zeroed bests
    always_comb begin
        in_window  = (s1_idx_q >= IDX_W'(BIN_LO)) && (s1_idx_q <= IDX_W'(BIN_HI));
        above_min  = (s1_mag_q > MAG_W'(MIN_MAG));
        base_mag   = (state_q == ST_REPORT) ? '0 : best_mag_q;
        base_idx   = (state_q == ST_REPORT) ? '0 : best_idx_q;
        base_found = (state_q == ST_REPORT) ? 1'b0 : best_found_q;
        win        = s1_valid_q & in_window & above_min & (s1_mag_q > base_mag);
        post_mag   = win ? s1_mag_q : base_mag;
        post_idx   = win ? s1_idx_q : base_idx;
        post_found = win | base_found;
        close_s1   = s1_valid_q & s1_last_q;
    end

    // Best tracking clears on frame close; result registers load the post-compare best
    always_comb begin
        best_mag_d   = close_s1 ? '0 : post_mag;
        best_idx_d   = close_s1 ? '0 : post_idx;
        best_found_d = close_s1 ? 1'b0 : post_found;
        out_idx_d    = out_idx_q;
        out_mag_d    = out_mag_q;
        out_found_d  = out_found_q;
        out_ovr_d    = out_ovr_q;
        if (close_s1) begin
            out_idx_d   = 32'(post_idx);
            out_mag_d   = post_mag;
            out_found_d = post_found;
            out_ovr_d   = s1_ovr_q;
        end
    end

    // Best and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            best_mag_q   <= '0;
            best_idx_q   <= '0;
            best_found_q <= 1'b0;
            out_idx_q    <= '0;
            out_mag_q    <= '0;
            out_found_q  <= 1'b0;
            out_ovr_q    <= 1'b0;
        end else begin
            best_mag_q   <= best_mag_d;
            best_idx_q   <= best_idx_d;
            best_found_q <= best_found_d;
            out_idx_q    <= out_idx_d;
            out_mag_q    <= out_mag_d;
            out_found_q  <= out_found_d;
            out_ovr_q    <= out_ovr_d;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a closing beat always goes to REPORT, even straight from REPORT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s1_valid_q) begin
                    state_d = s1_last_q ? ST_REPORT : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (s1_valid_q && s1_last_q) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (s1_valid_q) begin
                    state_d = s1_last_q ? ST_REPORT : ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and result ports
    always_comb begin
        o_valid        = (state_q == ST_REPORT);
        o_dbg_state    = state_q;
        o_f_domain_idx = out_idx_q;
        o_peak_mag     = out_mag_q;
        o_found        = out_found_q;
        o_overrun      = out_ovr_q;
    end

endmodule

// File: tb/tb_fft_peak_pick.sv
// Testbench for fft_peak_pick: directed frames, expected reports queued with
// their due cycle (closing beat + 2) and checked by a negedge monitor.
module tb_fft_peak_pick;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic [DW-1:0] i_re;
    logic [DW-1:0] i_im;
    logic          i_last;
    logic          o_valid;
    logic [31:0]   o_f_domain_idx;
    logic [31:0]   o_peak_mag;
    logic          o_found;
    logic          o_overrun;
    logic [1:0]    o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_beat_cyc = 0;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] idx;
        logic [31:0] mag;
        logic        found;
        logic        ovr;
    } exp_t;

    exp_t exp_q[$];

    fft_peak_pick dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_re           (i_re),
        .i_im           (i_im),
        .i_last         (i_last),
        .o_valid        (o_valid),
        .o_f_domain_idx (o_f_domain_idx),
        .o_peak_mag     (o_peak_mag),
        .o_found        (o_found),
        .o_overrun      (o_overrun),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int idx, input int mag, input bit found, input bit ovr);
        exp_t e;
        e.due   = 32'(last_beat_cyc + 2);
        e.idx   = 32'(idx);
        e.mag   = 32'(mag);
        e.found = found;
        e.ovr   = ovr;
        exp_q.push_back(e);
    endtask

    task automatic beat(input int re, input int im, input bit last);
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_re    = DW'(re);
        i_im    = DW'(im);
        i_last  = last;
        last_beat_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
            i_re    = '0;
            i_im    = '0;
        end
    endtask

    // One frame of len beats, zero except up to three bins; optional gap before bin gap_at
    task automatic frame(input int len,
                         input int pa, input int ra, input int ia,
                         input int pb, input int rb, input int ib,
                         input int pc, input int rc, input int ic,
                         input int gap_at, input int gap_len);
        for (int k = 0; k < len; k++) begin
            int re;
            int im;
            re = 0;
            im = 0;
            if (k == pa) begin re = ra; im = ia; end
            if (k == pb) begin re = rb; im = ib; end
            if (k == pc) begin re = rc; im = ic; end
            if (k == gap_at) idle(gap_len);
            beat(re, im, k == len - 1);
        end
    endtask

    // Monitor: o_valid must pulse exactly on each queued due cycle and never otherwise
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == 32'(cyc));
        chk("o_valid", {31'd0, o_valid}, {31'd0, exp_v});
        if (exp_v) begin
            e = exp_q.pop_front();
            chk("idx", o_f_domain_idx, e.idx);
            chk("mag", o_peak_mag, e.mag);
            chk("found", {31'd0, o_found}, {31'd0, e.found});
            chk("overrun", {31'd0, o_overrun}, {31'd0, e.ovr});
        end
    end

    initial begin
        int w;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_re    = '0;
        i_im    = '0;
        i_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idx", o_f_domain_idx, 32'd0);
        chk("rst_mag", o_peak_mag, 32'd0);
        chk("rst_found", {31'd0, o_found}, 32'd0);
        chk("rst_ovr", {31'd0, o_overrun}, 32'd0);
        chk("rst_state", {30'd0, o_dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Single peak at bin 20
        frame(64, 20, 100, 0, -1, 0, 0, -1, 0, 0, -1, 0);
        push_exp(20, 10000, 1'b1, 1'b0);
        idle(4);

        // Tie: lower index wins
        frame(64, 30, 0, 150, 40, 0, 150, -1, 0, 0, -1, 0);
        push_exp(30, 22500, 1'b1, 1'b0);
        idle(4);

        // Out-of-window strong bins ignored; in-window bin above threshold wins
        frame(64, 5, 1000, 0, 60, 1000, 0, 25, 70, 0, -1, 0);
        push_exp(25, 4900, 1'b1, 1'b0);
        idle(4);

        // Magnitude equal to threshold does not qualify
        frame(64, 5, 1000, 0, 60, 1000, 0, 25, 64, 0, -1, 0);
        push_exp(0, 0, 1'b0, 1'b0);
        idle(4);

        // Lower window edge inclusive, neighbours just outside excluded
        frame(64, 12, 500, 0, 13, 90, 0, 58, 500, 0, -1, 0);
        push_exp(13, 8100, 1'b1, 1'b0);
        idle(4);

        // Back-to-back frames: A with a 3-cycle gap, B starts the cycle after A's last
        frame(64, 15, 80, 0, 20, 0, 60, -1, 0, 0, 10, 3);
        push_exp(15, 6400, 1'b1, 1'b0);
        frame(64, 57, 200, 0, 0, 3000, 0, 20, 75, 0, -1, 0);
        push_exp(57, 40000, 1'b1, 1'b0);
        idle(4);

        // Overrun: 600 beats, frame closed by index limit at beat 511
        for (int k = 0; k < 600; k++) begin
            int re;
            re = 0;
            if (k == 40)  re = 150;
            if (k == 526) re = 120;
            beat(re, 0, k == 599);
            if (k == 511) push_exp(40, 22500, 1'b1, 1'b1);
            if (k == 599) push_exp(14, 14400, 1'b1, 1'b0);
        end
        idle(4);

        // Reset mid-frame: the partial frame is discarded, reset drops the same-cycle beat
        for (int k = 0; k < 30; k++) begin
            beat((k == 20) ? 100 : 0, 0, 1'b0);
        end
        @(posedge clk);
        #1;
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_re    = DW'(5000);
        i_im    = '0;
        i_last  = 1'b0;
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_re    = '0;
        @(negedge clk);
        chk("mid_rst_idx", o_f_domain_idx, 32'd0);
        chk("mid_rst_mag", o_peak_mag, 32'd0);
        chk("mid_rst_found", {31'd0, o_found}, 32'd0);
        chk("mid_rst_ovr", {31'd0, o_overrun}, 32'd0);
        chk("mid_rst_state", {30'd0, o_dbg_state}, 32'd0);
        idle(6);

        // Clean frame after reset, peak at bin 50
        frame(64, 50, 300, 0, -1, 0, 0, -1, 0, 0, -1, 0);
        push_exp(50, 90000, 1'b1, 1'b0);
        idle(2);

        // Drain with a bounded wait
        w = 0;
        while (exp_q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
